vga_plot_arbiter: RTL

//  Shares the single vga_adapter pixel-write port (x, y, colour, plot) between two

---
 rtl/vga_plot_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing the vga_adapter pixel-write port between two drawing
// engines, with bounded bursts, off-screen clipping and a registered output stage.
`timescale 1ns/1ps

// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; picks the next owner, no pixel accepted this cycle
// OWN0  | requester 0 owns the port; pixel taken whenever req0 is high
// OWN1  | requester 1 owns the port; pixel taken whenever req1 is high
module vga_plot_arbiter #(
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int C_W       = 3,
    parameter int X_MAX     = 160,
    parameter int Y_MAX     = 120,
    parameter int MAX_BURST = 16
) (
    input  logic           CLOCK_50,
    input  logic           resetn,
    input  logic           req0,
    input  logic           req1,
    input  logic [X_W-1:0] x0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y0,
    input  logic [Y_W-1:0] y1,
    input  logic [C_W-1:0] c0,
    input  logic [C_W-1:0] c1,
    output logic           gnt0,
    output logic           gnt1,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [C_W-1:0] vga_colour,
    output logic           vga_plot,
    output logic           busy
);

    localparam int BC_W = $clog2(MAX_BURST + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic            last;
    logic            last_nxt;
    logic [BC_W-1:0] bcnt;
    logic [BC_W-1:0] bcnt_nxt;
    logic [BC_W-1:0] bcnt_inc;
    logic            burst_end;

    logic            acc0;
    logic            acc1;
    logic [X_W-1:0]  sel_x;
    logic [Y_W-1:0]  sel_y;
    logic [C_W-1:0]  sel_c;
    logic            on_screen;

    // Grants come from the state register alone so there is no req->gnt path.
    assign gnt0 = (state == OWN0);
    assign gnt1 = (state == OWN1);
    assign busy = (state != IDLE);

    assign acc0 = gnt0 & req0;
    assign acc1 = gnt1 & req1;

    assign bcnt_inc  = bcnt + BC_W'(1);
    assign burst_end = (bcnt_inc == BC_W'(MAX_BURST));

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        bcnt_nxt  = bcnt;
        case (state)
            IDLE: begin
                bcnt_nxt = '0;
                if (req0 && req1) begin
                    state_nxt = last ? OWN0 : OWN1;
                end else if (req0) begin
                    state_nxt = OWN0;
                end else if (req1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    bcnt_nxt  = '0;
                    state_nxt = req1 ? OWN1 : IDLE;
                end else begin
                    last_nxt = 1'b0;
                    if (burst_end) begin
                        // Burst counter wraps even with no contender so the idle side
                        // is never starved once it starts asking.
                        bcnt_nxt = '0;
                        if (req1) begin
                            state_nxt = OWN1;
                        end
                    end else begin
                        bcnt_nxt = bcnt_inc;
                    end
                end
            end
            OWN1: begin
                if (!req1) begin
                    bcnt_nxt  = '0;
                    state_nxt = req0 ? OWN0 : IDLE;
                end else begin
                    last_nxt = 1'b1;
                    if (burst_end) begin
                        bcnt_nxt = '0;
                        if (req0) begin
                            state_nxt = OWN0;
                        end
                    end else begin
                        bcnt_nxt = bcnt_inc;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                bcnt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            last  <= 1'b1;
            bcnt  <= '0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            bcnt  <= bcnt_nxt;
        end
    end

    assign sel_x = acc1 ? x1 : x0;
    assign sel_y = acc1 ? y1 : y0;
    assign sel_c = acc1 ? c1 : c0;

    // Off-screen pixels are still accepted, just never strobed into the adapter.
    assign on_screen = (32'(sel_x) < 32'(X_MAX)) && (32'(sel_y) < 32'(Y_MAX));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else if (acc0 || acc1) begin
            vga_x      <= sel_x;
            vga_y      <= sel_y;
            vga_colour <= sel_c;
            vga_plot   <= on_screen;
        end else begin
            vga_plot   <= 1'b0;
        end
    end

endmodule
